// File: rtl/acq_sequencer_if.sv
// Buffer-read and UART-stream signals between the acquisition sequencer and its
// neighbours: the sequencer is the master, the buffer/UART side is the slave.
interface acq_sequencer_if #(
   parameter int DATA_W = 14,
   parameter int IDX_W  = 10
);
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output rd_idx, tx_data, tx_valid,
      input  rd_data, tx_ready
   );

   modport slave (
      input  rd_idx, tx_data, tx_valid,
      output rd_data, tx_ready
   );
endinterface

// File: rtl/acq_sequencer.sv
// Acquisition frame sequencer: threshold/forced trigger, capture window wait,
// then sample-by-sample readout of the waveform buffer to the UART framer.
module acq_sequencer #(
   parameter int N_SAMPLES = 1000,
   parameter int DATA_W    = 14,
   parameter int HOLDOFF   = 16,
   parameter int IDX_W     = $clog2(N_SAMPLES)
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              single_shot,
   input  logic              force_trig,
   input  logic [DATA_W-1:0] threshold,
   input  logic [DATA_W-1:0] signal,
   output logic              trigger,
   output logic              armed,
   output logic              busy,
   output logic [15:0]       frame_count,
   output logic [7:0]        missed_trig,
   acq_sequencer_if.master   bus
);

   localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARMED   = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_FETCH   = 3'd3;
   localparam logic [2:0] S_SEND    = 3'd4;
   localparam logic [2:0] S_HOLDOFF = 3'd5;

   logic [2:0]        state_reg;
   logic [DATA_W-1:0] prev_sig_reg;
   logic              trigger_reg;
   logic [IDX_W-1:0]  cap_cnt_reg;
   logic [IDX_W-1:0]  rd_idx_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [DATA_W-1:0] tx_data_reg;
   logic              tx_valid_reg;
   logic [15:0]       frame_count_reg;
   logic [7:0]        missed_reg;

   logic crossing;
   logic trig_event;
   logic busy_state;

   assign crossing   = (prev_sig_reg < threshold) && (signal >= threshold);
   assign trig_event = crossing || force_trig;
   assign busy_state = (state_reg == S_CAPTURE) || (state_reg == S_FETCH) ||
                       (state_reg == S_SEND)    || (state_reg == S_HOLDOFF);

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_reg       <= S_IDLE;
         prev_sig_reg    <= '0;
         trigger_reg     <= 1'b0;
         cap_cnt_reg     <= '0;
         rd_idx_reg      <= '0;
         hold_cnt_reg    <= '0;
         tx_data_reg     <= '0;
         tx_valid_reg    <= 1'b0;
         frame_count_reg <= '0;
         missed_reg      <= '0;
      end else begin
         prev_sig_reg <= signal;
         trigger_reg  <= 1'b0;

         if (busy_state && trig_event && (missed_reg != 8'hFF))
            missed_reg <= missed_reg + 8'd1;

         if (abort) begin
            state_reg    <= S_IDLE;
            tx_valid_reg <= 1'b0;
            rd_idx_reg   <= '0;
         end else begin
            case (state_reg)
               S_IDLE: begin
                  if (arm) begin
                     state_reg  <= S_ARMED;
                     rd_idx_reg <= '0;
                  end
               end
               S_ARMED: begin
                  if (trig_event) begin
                     trigger_reg <= 1'b1;
                     cap_cnt_reg <= '0;
                     state_reg   <= S_CAPTURE;
                  end
               end
               S_CAPTURE: begin
                  // The generator stores its first sample the cycle after the
                  // trigger pulse, so the window count starts one cycle late.
                  if (!trigger_reg) begin
                     if (cap_cnt_reg == IDX_W'(N_SAMPLES - 1)) begin
                        state_reg  <= S_FETCH;
                        rd_idx_reg <= '0;
                     end else begin
                        cap_cnt_reg <= cap_cnt_reg + 1'b1;
                     end
                  end
               end
               S_FETCH: begin
                  tx_data_reg  <= bus.rd_data;
                  tx_valid_reg <= 1'b1;
                  state_reg    <= S_SEND;
               end
               S_SEND: begin
                  if (bus.tx_ready) begin
                     tx_valid_reg <= 1'b0;
                     if (rd_idx_reg == IDX_W'(N_SAMPLES - 1)) begin
                        frame_count_reg <= frame_count_reg + 16'd1;
                        hold_cnt_reg    <= '0;
                        state_reg       <= S_HOLDOFF;
                     end else begin
                        rd_idx_reg <= rd_idx_reg + 1'b1;
                        state_reg  <= S_FETCH;
                     end
                  end
               end
               S_HOLDOFF: begin
                  if (hold_cnt_reg == HOLD_W'(HOLDOFF - 1)) begin
                     state_reg  <= single_shot ? S_IDLE : S_ARMED;
                     rd_idx_reg <= '0;
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg + 1'b1;
                  end
               end
               default: state_reg <= S_IDLE;
            endcase
         end
      end
   end

   assign trigger      = trigger_reg;
   assign armed        = (state_reg == S_ARMED);
   assign busy         = busy_state;
   assign frame_count  = frame_count_reg;
   assign missed_trig  = missed_reg;
   assign bus.rd_idx   = rd_idx_reg;
   assign bus.tx_data  = tx_data_reg;
   assign bus.tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: trigger timing, readout order and stalls,
// holdoff/re-arm, missed-trigger saturation, abort and mid-frame reset.
module tb_acq_sequencer;

   localparam int N_SAMPLES = 1000;
   localparam int DATA_W    = 14;
   localparam int HOLDOFF   = 16;
   localparam int IDX_W     = $clog2(N_SAMPLES);

   logic              sys_clk;
   logic              reset_n;
   logic              arm;
   logic              abort;
   logic              single_shot;
   logic              force_trig;
   logic [DATA_W-1:0] threshold;
   logic [DATA_W-1:0] signal;
   logic              trigger;
   logic              armed;
   logic              busy;
   logic [15:0]       frame_count;
   logic [7:0]        missed_trig;

   int n_tests = 0;
   int n_fail  = 0;

   acq_sequencer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   // Buffer model: word at address i holds i.
   assign bus.rd_data = {{(DATA_W - IDX_W){1'b0}}, bus.rd_idx};

   acq_sequencer #(
      .N_SAMPLES (N_SAMPLES),
      .DATA_W    (DATA_W),
      .HOLDOFF   (HOLDOFF),
      .IDX_W     (IDX_W)
   ) dut (
      .sys_clk     (sys_clk),
      .reset_n     (reset_n),
      .arm         (arm),
      .abort       (abort),
      .single_shot (single_shot),
      .force_trig  (force_trig),
      .threshold   (threshold),
      .signal      (signal),
      .trigger     (trigger),
      .armed       (armed),
      .busy        (busy),
      .frame_count (frame_count),
      .missed_trig (missed_trig),
      .bus         (bus)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Holds tx_ready high and consumes n words, checking they arrive as 0,1,2...
   task automatic stream(input int n, input string tag);
      int idx = 0;
      int bad = 0;
      int cyc = 0;
      bus.tx_ready = 1'b1;
      while (idx < n && cyc < 6000) begin
         if (bus.tx_valid) begin
            if (32'(bus.tx_data) != idx) bad++;
            idx++;
         end
         tick();
         cyc++;
      end
      check_eq({tag, "_count"}, idx, n);
      check_eq({tag, "_data"}, bad, 0);
      $display("[TB] %s: streamed %0d words in %0d cycles", tag, idx, cyc);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_trigger"},  32'(trigger), 0);
      check_eq({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
      check_eq({tag, "_armed"},    32'(armed), 0);
      check_eq({tag, "_busy"},     32'(busy), 0);
      check_eq({tag, "_frames"},   32'(frame_count), 0);
      check_eq({tag, "_missed"},   32'(missed_trig), 0);
      check_eq({tag, "_rd_idx"},   32'(bus.rd_idx), 0);
      check_eq({tag, "_tx_data"},  32'(bus.tx_data), 0);
   endtask

   initial begin
      int cyc;
      int bad;
      int bad_trig;

      reset_n      = 1'b0;
      arm          = 1'b0;
      abort        = 1'b0;
      single_shot  = 1'b1;
      force_trig   = 1'b0;
      threshold    = 14'h0800;
      signal       = 14'h07FF;
      bus.tx_ready = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      $display("[TB] reset state checked");

      reset_n = 1'b1;
      tick();

      // IDLE ignores both trigger sources
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check_eq("idle_force_trigger", 32'(trigger), 0);
      check_eq("idle_force_armed", 32'(armed), 0);
      signal = 14'h0800;
      tick();
      check_eq("idle_cross_trigger", 32'(trigger), 0);
      $display("[TB] idle ignores force_trig and crossing");

      // Test 1: rising crossing exactly at threshold
      signal = 14'h07FF;
      arm    = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("arm_armed", 32'(armed), 1);
      signal = 14'h0800;
      tick();
      check_eq("t1_trigger", 32'(trigger), 1);
      check_eq("t1_busy", 32'(busy), 1);
      check_eq("t1_armed", 32'(armed), 0);
      $display("[TB] crossing 0x07FF->0x0800 fired trigger");

      // Test 5a: three crossings during CAPTURE
      cyc      = 0;
      bad_trig = 0;
      for (int k = 0; k < 3; k++) begin
         signal = 14'h07FF;
         tick();
         cyc++;
         if (trigger) bad_trig++;
         signal = 14'h0800;
         tick();
         cyc++;
         if (trigger) bad_trig++;
      end
      check_eq("t5_no_retrigger", bad_trig, 0);
      check_eq("t5_missed3", 32'(missed_trig), 3);
      $display("[TB] three crossings during capture counted as missed");

      while (!bus.tx_valid && cyc < 1100) begin
         tick();
         cyc++;
      end
      check_eq("t1_first_valid_latency", cyc, N_SAMPLES + 2);
      $display("[TB] first tx_valid %0d cycles after trigger", cyc);

      // Tests 2/3: full readout, one word every 2 cycles, 5-cycle stall at word 3
      bus.tx_ready = 1'b1;
      bad = 0;
      for (int e = 0; e < N_SAMPLES; e++) begin
         if (e == 3) begin
            bus.tx_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               check_eq("t3_stall_valid", 32'(bus.tx_valid), 1);
               check_eq("t3_stall_data", 32'(bus.tx_data), 3);
            end
            bus.tx_ready = 1'b1;
         end
         if (e == 4) check_eq("t3_next_word", 32'(bus.tx_data), 4);
         if (!bus.tx_valid || 32'(bus.tx_data) != e) bad++;
         tick();
         if (e < N_SAMPLES - 1) begin
            if (bus.tx_valid) bad++;
            tick();
         end
      end
      check_eq("t2_words", bad, 0);
      check_eq("t2_frame_count", 32'(frame_count), 1);
      check_eq("t2_valid_after_last", 32'(bus.tx_valid), 0);
      repeat (HOLDOFF - 1) tick();
      check_eq("t2_holdoff_busy", 32'(busy), 1);
      tick();
      check_eq("t2_idle_busy", 32'(busy), 0);
      check_eq("t2_idle_armed", 32'(armed), 0);
      check_eq("t2_idle_rd_idx", 32'(bus.rd_idx), 0);
      $display("[TB] frame 1 read out, single-shot returned to IDLE");

      // Test 4: continuous mode with forced trigger, holdoff length, no retrigger
      single_shot = 1'b0;
      signal      = 14'h0FFF;
      arm         = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("t4_armed", 32'(armed), 1);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check_eq("t4_trigger", 32'(trigger), 1);
      stream(N_SAMPLES, "t4_stream");
      check_eq("t4_frame_count", 32'(frame_count), 2);
      repeat (HOLDOFF - 1) tick();
      check_eq("t4_holdoff_end_armed", 32'(armed), 0);
      tick();
      check_eq("t4_rearmed", 32'(armed), 1);
      check_eq("t4_rearm_rd_idx", 32'(bus.rd_idx), 0);
      bad_trig = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (trigger) bad_trig++;
      end
      check_eq("t4_no_retrigger", bad_trig, 0);
      check_eq("t4_still_armed", 32'(armed), 1);
      $display("[TB] continuous mode re-armed after holdoff");

      // Test 5b: missed_trig saturates
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check_eq("t5_trigger", 32'(trigger), 1);
      bad_trig = 0;
      for (int k = 0; k < 300; k++) begin
         signal = 14'h07FF;
         tick();
         if (trigger) bad_trig++;
         signal = 14'h0800;
         tick();
         if (trigger) bad_trig++;
      end
      check_eq("t5_sat_no_retrigger", bad_trig, 0);
      check_eq("t5_missed_sat", 32'(missed_trig), 255);
      check_eq("t5_busy", 32'(busy), 1);
      $display("[TB] missed_trig saturated");

      // Test 6: abort mid-readout
      stream(500, "t6_stream");
      tick();
      check_eq("t6_pre_valid", 32'(bus.tx_valid), 1);
      check_eq("t6_pre_data", 32'(bus.tx_data), 500);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t6_abort_valid", 32'(bus.tx_valid), 0);
      check_eq("t6_abort_busy", 32'(busy), 0);
      check_eq("t6_abort_armed", 32'(armed), 0);
      check_eq("t6_abort_frames", 32'(frame_count), 2);
      check_eq("t6_abort_missed", 32'(missed_trig), 255);
      check_eq("t6_abort_rd_idx", 32'(bus.rd_idx), 0);
      $display("[TB] abort during readout returned to IDLE");

      arm   = 1'b1;
      abort = 1'b1;
      tick();
      arm   = 1'b0;
      abort = 1'b0;
      check_eq("t6_arm_abort_armed", 32'(armed), 0);
      check_eq("t6_arm_abort_busy", 32'(busy), 0);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check_eq("t6_rearm", 32'(armed), 1);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check_eq("t6_trigger", 32'(trigger), 1);
      repeat (10) tick();
      check_eq("t6_capture_busy", 32'(busy), 1);
      reset_n = 1'b0;
      tick();
      check_all_zero("t6_reset");
      reset_n = 1'b1;
      tick();
      $display("[TB] arm+abort and mid-capture reset checked");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
